// File: rtl/mcu_el2_pkg.sv
// Shared types for the EL2 DCCM blocks.
package mcu_el2_pkg;

    // DCCM init controller states
    typedef enum logic [1:0] {
        DCCM_IDLE  = 2'd0,
        DCCM_INIT  = 2'd1,
        DCCM_LAST  = 2'd2,
        DCCM_READY = 2'd3
    } mcu_el2_dccm_init_state_t;

endpackage

// File: rtl/mcu_el2_dccm_init_ctrl.sv
// DCCM init controller: sweeps every row of all banks with a fixed pattern,
// then hands the SRAM ports to the core as a zero-latency passthrough.
module mcu_el2_dccm_init_ctrl
    import mcu_el2_pkg::*;
#(
    parameter int unsigned          NUM_BANKS = 4,
    parameter int unsigned          ROW_W     = 12,
    parameter int unsigned          DATA_W    = 39,
    parameter int unsigned          ECC_W     = 7,
    parameter logic [DATA_W-1:0]    INIT_DATA = '0,
    parameter logic [ECC_W-1:0]     INIT_ECC  = '0,
    parameter bit                   AUTO_INIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          init_start,
    input  logic [NUM_BANKS-1:0]          core_clken,
    input  logic [NUM_BANKS-1:0]          core_wren,
    input  logic [NUM_BANKS*ROW_W-1:0]    core_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]   core_wr_data,
    input  logic [NUM_BANKS*ECC_W-1:0]    core_wr_ecc,
    output logic [NUM_BANKS-1:0]          mem_clken,
    output logic [NUM_BANKS-1:0]          mem_wren,
    output logic [NUM_BANKS*ROW_W-1:0]    mem_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_wr_data,
    output logic [NUM_BANKS*ECC_W-1:0]    mem_wr_ecc,
    output logic                          core_stall,
    output logic                          init_busy,
    output logic                          init_done
);

    localparam logic [ROW_W-1:0] ROW_LAST = '1;
    localparam mcu_el2_dccm_init_state_t RST_STATE = AUTO_INIT ? DCCM_INIT : DCCM_IDLE;

    mcu_el2_dccm_init_state_t state;
    mcu_el2_dccm_init_state_t state_nxt;
    logic [ROW_W-1:0]         row_cnt;

    // State register; reset parks directly in the post-reset target state
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; init_start is only honoured outside an active sweep
    always_comb begin
        state_nxt = state;
        case (state)
            DCCM_IDLE:  if (init_start) state_nxt = DCCM_INIT;
            DCCM_INIT:  if (row_cnt == ROW_LAST) state_nxt = DCCM_LAST;
            DCCM_LAST:  state_nxt = DCCM_READY;
            DCCM_READY: if (init_start) state_nxt = DCCM_INIT;
            default:    state_nxt = RST_STATE;
        endcase
    end

    // Row counter: held at zero outside INIT so every sweep starts at row 0
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            row_cnt <= '0;
        end else if ((state == DCCM_INIT) && (row_cnt != ROW_LAST)) begin
            row_cnt <= row_cnt + ROW_W'(1);
        end else begin
            row_cnt <= '0;
        end
    end

    // Sticky completion flag, set as LAST hands over to READY
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            init_done <= 1'b0;
        end else if (state == DCCM_LAST) begin
            init_done <= 1'b1;
        end
    end

    // Output mux; gated by rst_l so nothing reaches the SRAM while in reset
    always_comb begin
        mem_clken   = '0;
        mem_wren    = '0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ecc  = '0;
        core_stall  = 1'b1;
        init_busy   = 1'b0;
        if (rst_l) begin
            case (state)
                DCCM_IDLE, DCCM_READY: begin
                    mem_clken   = core_clken;
                    mem_wren    = core_wren;
                    mem_addr    = core_addr;
                    mem_wr_data = core_wr_data;
                    mem_wr_ecc  = core_wr_ecc;
                    core_stall  = (state != DCCM_READY);
                end
                DCCM_INIT: begin
                    mem_clken   = '1;
                    mem_wren    = '1;
                    mem_addr    = {NUM_BANKS{row_cnt}};
                    mem_wr_data = {NUM_BANKS{INIT_DATA}};
                    mem_wr_ecc  = {NUM_BANKS{INIT_ECC}};
                    init_busy   = 1'b1;
                end
                DCCM_LAST: begin
                    init_busy   = 1'b1;
                end
                default: begin
                    core_stall  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_el2_dccm_init_ctrl.sv
// Scoreboard bench for the DCCM init controller: expected SRAM writes are
// queued by the stimulus and popped by an independent monitor.
module tb_mcu_el2_dccm_init_ctrl;

    localparam int unsigned NB   = 4;
    localparam int unsigned RW   = 4;
    localparam int unsigned DW   = 39;
    localparam int unsigned EW   = 7;
    localparam int unsigned ROWS = 16;
    localparam logic [DW-1:0] INIT_D = 39'h12_3456_789A;
    localparam logic [EW-1:0] INIT_E = 7'h55;

    typedef struct packed {
        logic [NB-1:0]    clken;
        logic [NB-1:0]    wren;
        logic [NB*RW-1:0] addr;
        logic [NB*DW-1:0] data;
        logic [NB*EW-1:0] ecc;
    } wr_t;

    logic clk;
    logic rst_l, rst_b;
    logic init_start, init_start_b;
    logic [NB-1:0]    core_clken, core_wren;
    logic [NB*RW-1:0] core_addr;
    logic [NB*DW-1:0] core_wr_data;
    logic [NB*EW-1:0] core_wr_ecc;
    logic [NB-1:0]    mem_clken, mem_wren;
    logic [NB*RW-1:0] mem_addr;
    logic [NB*DW-1:0] mem_wr_data;
    logic [NB*EW-1:0] mem_wr_ecc;
    logic core_stall, init_busy, init_done;

    logic [NB-1:0]    b_core_en;
    logic [NB*RW-1:0] b_core_addr;
    logic [NB*DW-1:0] b_core_data;
    logic [NB*EW-1:0] b_core_ecc;
    logic [NB-1:0]    b_mem_clken, b_mem_wren;
    logic [NB*RW-1:0] b_mem_addr;
    logic [NB*DW-1:0] b_mem_wr_data;
    logic [NB*EW-1:0] b_mem_wr_ecc;
    logic b_stall, b_busy, b_done;

    wr_t exp_q[$];
    wr_t mon_got, mon_exp;
    int  total = 0;
    int  bad   = 0;
    int  nwr   = 0;

    mcu_el2_dccm_init_ctrl #(
        .NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW),
        .INIT_DATA(INIT_D), .INIT_ECC(INIT_E), .AUTO_INIT(1'b1)
    ) dut (
        .clk(clk), .rst_l(rst_l), .init_start(init_start),
        .core_clken(core_clken), .core_wren(core_wren), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_wr_ecc(core_wr_ecc),
        .mem_clken(mem_clken), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ecc(mem_wr_ecc),
        .core_stall(core_stall), .init_busy(init_busy), .init_done(init_done)
    );

    mcu_el2_dccm_init_ctrl #(
        .NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW),
        .INIT_DATA(INIT_D), .INIT_ECC(INIT_E), .AUTO_INIT(1'b0)
    ) dut_b (
        .clk(clk), .rst_l(rst_b), .init_start(init_start_b),
        .core_clken(b_core_en), .core_wren(b_core_en), .core_addr(b_core_addr),
        .core_wr_data(b_core_data), .core_wr_ecc(b_core_ecc),
        .mem_clken(b_mem_clken), .mem_wren(b_mem_wren), .mem_addr(b_mem_addr),
        .mem_wr_data(b_mem_wr_data), .mem_wr_ecc(b_mem_wr_ecc),
        .core_stall(b_stall), .init_busy(b_busy), .init_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a full sweep writes every row, all banks, with the fixed pattern
    task automatic push_init(input int rows);
        wr_t rec;
        logic [RW-1:0] rr;
        for (int r = 0; r < rows; r++) begin
            rr        = RW'(r);
            rec.clken = '1;
            rec.wren  = '1;
            rec.addr  = {NB{rr}};
            rec.data  = {NB{INIT_D}};
            rec.ecc   = {NB{INIT_E}};
            exp_q.push_back(rec);
        end
    endtask

    task automatic push_core();
        if ((core_clken | core_wren) != '0)
            exp_q.push_back({core_clken, core_wren, core_addr, core_wr_data, core_wr_ecc});
    endtask

    // Random core request; queued as expected only when the core owns the SRAM
    task automatic drive_rand(input bit pass);
        core_clken  = NB'($urandom);
        core_wren   = NB'($urandom);
        core_addr   = (NB*RW)'($urandom);
        for (int b = 0; b < int'(NB); b++)
            core_wr_data[b*DW +: DW] = DW'({$urandom, $urandom});
        core_wr_ecc = (NB*EW)'($urandom);
        if (pass) push_core();
    endtask

    task automatic drive_zero();
        core_clken   = '0;
        core_wren    = '0;
        core_addr    = '0;
        core_wr_data = '0;
        core_wr_ecc  = '0;
    endtask

    // One full sweep + LAST + first READY cycle; entered and left at posedge+1
    task automatic run_init(input bit done_before, input int pulse_row);
        for (int k = 1; k <= int'(ROWS) + 2; k++) begin
            drive_rand(k == int'(ROWS) + 2);
            init_start = (k == pulse_row + 1);
            @(negedge clk);
            if (k <= int'(ROWS) + 1) begin
                chk($sformatf("init_k%0d_busy", k), 64'(init_busy), 64'(1));
                chk($sformatf("init_k%0d_stall", k), 64'(core_stall), 64'(1));
                chk($sformatf("init_k%0d_done", k), 64'(init_done), 64'(done_before));
            end else begin
                chk("ready_busy", 64'(init_busy), 64'(0));
                chk("ready_stall", 64'(core_stall), 64'(0));
                chk("ready_done", 64'(init_done), 64'(1));
            end
            if (k == int'(ROWS) + 1)
                chk("last_clken", 64'(mem_clken), 64'(0));
            @(posedge clk); #1;
        end
        init_start = 1'b0;
    endtask

    // Monitor: every cycle the SRAM sees an enable must match the queue head
    initial begin
        forever begin
            @(negedge clk);
            if ((mem_clken | mem_wren) != '0) begin
                mon_got = {mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc};
                total++;
                nwr++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got wren=%h addr=%h expected no write",
                             mem_wren, mem_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        bad++;
                        $display("FAIL write_%0d: got %h expected %h", nwr, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    // Main sequence
    initial begin
        rst_l = 1'b0; rst_b = 1'b0;
        init_start = 1'b0; init_start_b = 1'b0;
        drive_zero();
        b_core_en = '0; b_core_addr = '0; b_core_data = '0; b_core_ecc = '0;
        repeat (3) @(posedge clk);
        #1;
        drive_rand(1'b0);
        @(negedge clk);
        chk("rst_clken", 64'(mem_clken), 64'(0));
        chk("rst_wren", 64'(mem_wren), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_data", 64'(mem_wr_data[DW-1:0]), 64'(0));
        chk("rst_ecc", 64'(mem_wr_ecc), 64'(0));
        chk("rst_stall", 64'(core_stall), 64'(1));
        chk("rst_busy", 64'(init_busy), 64'(0));
        chk("rst_done", 64'(init_done), 64'(0));
        chk("rst_b_stall", 64'(b_stall), 64'(1));
        @(posedge clk); #1;

        fork
            begin
                // Auto-init after reset release
                push_init(ROWS);
                rst_l = 1'b1;
                run_init(1'b0, -1);

                // Directed passthrough on bank 1
                drive_zero();
                core_clken = 4'b0010;
                core_wren  = 4'b0010;
                core_addr[RW +: RW]    = RW'(5);
                core_wr_data[DW +: DW] = DW'(16'h1234);
                push_core();
                @(negedge clk);
                chk("pt_wren", 64'(mem_wren), 64'(4'b0010));
                chk("pt_addr1", 64'(mem_addr[RW +: RW]), 64'(5));
                chk("pt_data1", 64'(mem_wr_data[DW +: DW]), 64'(16'h1234));
                @(posedge clk); #1;

                // Random passthrough traffic in READY
                for (int i = 0; i < 20; i++) begin
                    drive_rand(1'b1);
                    @(negedge clk);
                    chk("pt_stall", 64'(core_stall), 64'(0));
                    @(posedge clk); #1;
                end

                // Re-init from READY under full core write; extra pulse at row 7
                drive_rand(1'b0);
                core_clken = '1;
                core_wren  = '1;
                push_core();
                init_start = 1'b1;
                @(negedge clk);
                chk("reinit_req_stall", 64'(core_stall), 64'(0));
                @(posedge clk); #1;
                init_start = 1'b0;
                push_init(ROWS);
                run_init(1'b1, 7);

                // Reset dropped while row 9 is on the bus
                drive_zero();
                init_start = 1'b1;
                @(negedge clk);
                @(posedge clk); #1;
                init_start = 1'b0;
                push_init(9);
                for (int k = 1; k <= 9; k++) begin
                    drive_rand(1'b0);
                    @(negedge clk);
                    chk("abort_busy", 64'(init_busy), 64'(1));
                    @(posedge clk); #1;
                end
                drive_rand(1'b0);
                rst_l = 1'b0;
                @(negedge clk);
                chk("abort_wren", 64'(mem_wren), 64'(0));
                chk("abort_clken", 64'(mem_clken), 64'(0));
                chk("abort_busy0", 64'(init_busy), 64'(0));
                chk("abort_stall", 64'(core_stall), 64'(1));
                chk("abort_done", 64'(init_done), 64'(0));
                @(posedge clk); #1;
                push_init(ROWS);
                rst_l = 1'b1;
                run_init(1'b0, -1);

                drive_zero();
                repeat (3) @(posedge clk);
                #1;
                chk("queue_empty", 64'(exp_q.size()), 64'(0));
            end
            begin
                // No auto-init: stays stalled and idle until asked
                rst_b = 1'b1;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    chk("noauto_stall", 64'(b_stall), 64'(1));
                    chk("noauto_clken", 64'(b_mem_clken), 64'(0));
                    chk("noauto_done", 64'(b_done), 64'(0));
                    @(posedge clk); #1;
                end
                init_start_b = 1'b1;
                @(negedge clk);
                @(posedge clk); #1;
                init_start_b = 1'b0;
                for (int k = 1; k <= int'(ROWS) + 2; k++) begin
                    @(negedge clk);
                    if (k <= int'(ROWS)) begin
                        chk("b_init_addr0", 64'(b_mem_addr[RW-1:0]), 64'(k - 1));
                    end else if (k == int'(ROWS) + 2) begin
                        chk("b_ready_done", 64'(b_done), 64'(1));
                        chk("b_ready_stall", 64'(b_stall), 64'(0));
                    end
                    @(posedge clk); #1;
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
